compare_block3_sched: RTL and testbench
=======================================

Name: compare_block3_sched

Overview:
- Sequencer for the max-pool/binarize compare stage (7x int8 window max, then per-channel threshold compare).
- Per output channel: fetches the 24-bit packed threshold, strobes it into the compare stage, then streams WIN_NUM 56-bit windows from the feature buffer.
- Collects the returned binary bits into PACK_W-bit words and hands them to the downstream writer via a valid/ready handshake.

Parameters:
- CH_NUM, 16, output channels per run.
- WIN_NUM, 32, pooling windows per channel.
- PACK_W, 8, binary bits per output word.
- WIN_AW, 10, window buffer address width; window address = ch*WIN_NUM + win.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; ignored unless idle.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last word of the last channel is accepted.
- thr_rd_en  out  1  threshold memory read strobe.
- thr_rd_addr  out  clog2(CH_NUM)  channel index.
- thr_rd_data  in  24  threshold word; valid 1 cycle after thr_rd_en.
- thr_out  out  24  threshold to the compare stage.
- thr_load  out  1  load strobe to the compare stage.
- win_rd_en  out  1  window buffer read strobe.
- win_rd_addr  out  WIN_AW  window address.
- win_rd_data  in  56  window data; valid 1 cycle after win_rd_en.
- cmp_data  out  56  window to the compare stage.
- cmp_binary  in  1  compare result.
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream ready.
- out_data  out  PACK_W  packed binary bits.
- out_ch  out  clog2(CH_NUM)  channel of out_data.
- out_last  out  1  last word of the channel.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- State machine:
  - IDLE -> THR_RD on start.
  - THR_RD: assert thr_rd_en for 1 cycle -> THR_CAP.
  - THR_CAP: register thr_rd_data into thr_out -> THR_LD.
  - THR_LD: thr_load=1 for exactly 1 cycle; thr_out is already stable 1 cycle before and stays stable until the next THR_CAP, because the compare stage latches on the strobe edge -> ISSUE.
  - ISSUE: one win_rd_en per cycle for min(PACK_W, remaining) windows -> DRAIN.
  - DRAIN: wait until all in-flight results are collected -> OUT.
  - OUT: hold out_valid until out_ready. Then:
    - more windows remain in the channel -> ISSUE;
    - else more channels remain -> THR_RD;
    - else -> DONE.
  - DONE: done=1 for 1 cycle -> IDLE.
- Datapath:
  - cmp_data is win_rd_data passed through combinationally.
  - Result latency: cmp_binary for the window read at cycle t is sampled at t+3 (1 memory cycle + 2 compare-stage registers). Track it with a 3-deep valid shift register; DRAIN exits when the shift register is empty.
  - Packing is LSB-first: bit i = i-th window of the group.
  - A partial final group (WIN_NUM % PACK_W != 0) is zero-padded in the upper bits.
  - out_last=1 on the final word of each channel.
- Handshake:
  - out_data, out_ch and out_last are stable while out_valid && !out_ready.
  - Transfer occurs when out_valid && out_ready; out_valid deasserts the next cycle unless a new word follows.
  - No window issue occurs while a word is pending, so backpressure never drops results.
- Boundaries:
  - start while busy is ignored.
  - rst mid-run returns to IDLE immediately; the in-flight pipeline and partial word are discarded, and no done pulse is produced.
  - out_ready held high: a word completes in PACK_W+4 cycles plus 1 for the handshake.
  - CH_NUM=1 and WIN_NUM<PACK_W must work.

Optional Feature:
- Macro CMP_SCHED_PERF_EN.
- Defined: adds output perf_stall_cnt (16 bits). It counts cycles with out_valid && !out_ready, saturates at 0xFFFF, clears on start and on rst.
- Undefined: the port and counter do not exist; the rest of the behaviour is identical.

Decomposition:
- Shared package holds:
  - constants THR_W=24, WIN_DW=56, MEM_LAT=1, CMP_LAT=2;
  - the state enum (IDLE, THR_RD, THR_CAP, THR_LD, ISSUE, DRAIN, OUT, DONE).
- One natural sub-module, cmp_bit_packer: takes the result-valid strobe and bit, plus group clear and final-group flag. It provides word assembly, zero padding and out_valid/out_ready holding.

Test Plan:
- CH_NUM=2, WIN_NUM=8, thresholds 0x7FF7FF/0x000000, out_ready=1 -> 2 words. Each has out_last=1; out_ch=0 then 1; bits match the golden compare model; done 1 cycle after the 2nd accept.
- thr_load check -> exactly 1 pulse per channel. thr_out is unchanged from 1 cycle before the pulse until the next THR_CAP, and never changes while results are in flight.
- WIN_NUM=10, PACK_W=8, all windows max=+5 with plus threshold below -> words 0xFF then 0x03 (zero-padded), out_last on the 2nd word only.
- out_ready low 20 cycles on the first word -> out_data/out_ch/out_last held stable, win_rd_en stays 0, no results lost.
- rst pulse during ISSUE of channel 1 -> all outputs 0 and no done pulse. A following start runs the full sequence correctly from channel 0.
- start pulsed while busy -> ignored; exactly one done per accepted start.

Source files
------------

// File: rtl/compare_block3_sched_pkg.sv
// ============================================================================
// Module      : compare_block3_sched_pkg
// Description : Shared constants, state encoding and helpers for the
//               max-pool/binarize compare-stage sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package compare_block3_sched_pkg;

    localparam int THR_W   = 24;
    localparam int WIN_DW  = 56;
    localparam int MEM_LAT = 1;
    localparam int CMP_LAT = 2;
    localparam int RES_LAT = MEM_LAT + CMP_LAT;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        THR_RD  = 3'd1,
        THR_CAP = 3'd2,
        THR_LD  = 3'd3,
        ISSUE   = 3'd4,
        DRAIN   = 3'd5,
        OUT     = 3'd6,
        DONE    = 3'd7
    } sched_state_t;

    // Index width that stays legal (>= 1 bit) for single-entry ranges.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/compare_block3_sched_cmp_bit_packer.sv
// ============================================================================
// Module      : cmp_bit_packer
// Description : Assembles compare result bits LSB-first into PACK_W-bit
//               words and holds each word on a valid/ready output port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_bit_packer #(
    parameter int PACK_W = 8,
    parameter int CH_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              grp_clr,
    input  logic              res_valid,
    input  logic              res_bit,
    input  logic              word_send,
    input  logic              word_last,
    input  logic [CH_W-1:0]   word_ch,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [PACK_W-1:0] out_data,
    output logic [CH_W-1:0]   out_ch,
    output logic              out_last,
    output logic              xfer
);

    localparam int c_IDX_W = $clog2(PACK_W + 1);

    logic [PACK_W-1:0]  r_word;
    logic [PACK_W-1:0]  w_word_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_valid;
    logic [PACK_W-1:0]  r_data;
    logic [CH_W-1:0]    r_ch;
    logic               r_last;

    // The bit arriving on the send cycle belongs to the word being sent.
    always_comb begin
        w_word_nxt = r_word;
        if (res_valid) begin
            for (int i = 0; i < PACK_W; i++) begin
                if (r_idx == c_IDX_W'(i)) begin
                    w_word_nxt[i] = res_bit;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word  <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_ch    <= '0;
            r_last  <= 1'b0;
        end else begin
            if (grp_clr || word_send) begin
                r_word <= '0;
                r_idx  <= '0;
            end else if (res_valid) begin
                r_word <= w_word_nxt;
                r_idx  <= r_idx + 1'b1;
            end

            if (word_send) begin
                r_valid <= 1'b1;
                r_data  <= w_word_nxt;
                r_ch    <= word_ch;
                r_last  <= word_last;
            end else if (xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_ch    = r_ch;
    assign out_last  = r_last;
    assign xfer      = r_valid && out_ready;

endmodule

`default_nettype wire

// File: rtl/compare_block3_sched.sv
// ============================================================================
// Module      : compare_block3_sched
// Description : Per-channel threshold fetch/load, window streaming and
//               result packing for the max-pool/binarize compare stage.
//               Optional macro CMP_SCHED_PERF_EN adds perf_stall_cnt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module compare_block3_sched
    import compare_block3_sched_pkg::*;
#(
    parameter int CH_NUM  = 16,
    parameter int WIN_NUM = 32,
    parameter int PACK_W  = 8,
    parameter int WIN_AW  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      thr_rd_en,
    output logic [idx_w(CH_NUM)-1:0]  thr_rd_addr,
    input  logic [THR_W-1:0]          thr_rd_data,
    output logic [THR_W-1:0]          thr_out,
    output logic                      thr_load,
    output logic                      win_rd_en,
    output logic [WIN_AW-1:0]         win_rd_addr,
    input  logic [WIN_DW-1:0]         win_rd_data,
    output logic [WIN_DW-1:0]         cmp_data,
    input  logic                      cmp_binary,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK_W-1:0]         out_data,
    output logic [idx_w(CH_NUM)-1:0]  out_ch,
    output logic                      out_last
`ifdef CMP_SCHED_PERF_EN
    ,
    output logic [15:0]               perf_stall_cnt
`endif
);

    localparam int c_CH_W = idx_w(CH_NUM);
    localparam int c_WC_W = $clog2(WIN_NUM + 1);
    localparam int c_GC_W = $clog2(PACK_W + 1);

    sched_state_t       r_state;
    sched_state_t       w_state_nxt;
    logic [c_CH_W-1:0]  r_ch;
    logic [c_WC_W-1:0]  r_win_cnt;
    logic [c_GC_W-1:0]  r_grp_cnt;
    logic [WIN_AW-1:0]  r_win_addr;
    logic [THR_W-1:0]   r_thr;
    logic [RES_LAT-1:0] r_res_vld;

    logic w_start_ok;
    logic w_grp_end;
    logic w_chan_end;
    logic w_last_ch;
    logic w_drain_end;
    logic w_xfer;

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_grp_end   = (r_grp_cnt == c_GC_W'(PACK_W - 1)) ||
                         (r_win_cnt == c_WC_W'(WIN_NUM - 1));
    assign w_chan_end  = (r_win_cnt == c_WC_W'(WIN_NUM));
    assign w_last_ch   = (r_ch == c_CH_W'(CH_NUM - 1));
    // The oldest slot is sampled this cycle, so only younger slots must be empty.
    assign w_drain_end = (r_state == DRAIN) && (r_res_vld[RES_LAT-2:0] == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        done        = 1'b0;
        thr_rd_en   = 1'b0;
        thr_load    = 1'b0;
        win_rd_en   = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_state_nxt = THR_RD;
            end
            THR_RD: begin
                thr_rd_en   = 1'b1;
                w_state_nxt = THR_CAP;
            end
            THR_CAP: begin
                w_state_nxt = THR_LD;
            end
            THR_LD: begin
                thr_load    = 1'b1;
                w_state_nxt = ISSUE;
            end
            ISSUE: begin
                win_rd_en = 1'b1;
                if (w_grp_end) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (w_drain_end) w_state_nxt = OUT;
            end
            OUT: begin
                if (w_xfer) begin
                    if (!w_chan_end)     w_state_nxt = ISSUE;
                    else if (!w_last_ch) w_state_nxt = THR_RD;
                    else                 w_state_nxt = DONE;
                end
            end
            DONE: begin
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ch       <= '0;
            r_win_cnt  <= '0;
            r_grp_cnt  <= '0;
            r_win_addr <= '0;
            r_thr      <= '0;
            r_res_vld  <= '0;
        end else begin
            r_res_vld <= {r_res_vld[RES_LAT-2:0], win_rd_en};
            if (w_start_ok) begin
                r_ch       <= '0;
                r_win_cnt  <= '0;
                r_grp_cnt  <= '0;
                r_win_addr <= '0;
            end
            if (r_state == THR_CAP) begin
                r_thr <= thr_rd_data;
            end
            // Channels run back to back, so the window address simply increments.
            if (win_rd_en) begin
                r_win_cnt  <= r_win_cnt + 1'b1;
                r_win_addr <= r_win_addr + 1'b1;
                r_grp_cnt  <= w_grp_end ? '0 : r_grp_cnt + 1'b1;
            end
            if ((r_state == OUT) && w_xfer && w_chan_end && !w_last_ch) begin
                r_win_cnt <= '0;
                r_ch      <= r_ch + 1'b1;
            end
        end
    end

    assign thr_rd_addr = r_ch;
    assign thr_out     = r_thr;
    assign win_rd_addr = r_win_addr;
    assign cmp_data    = win_rd_data;

    cmp_bit_packer #(
        .PACK_W (PACK_W),
        .CH_W   (c_CH_W)
    ) u_packer (
        .clk       (clk),
        .rst       (rst),
        .grp_clr   (w_start_ok),
        .res_valid (r_res_vld[RES_LAT-1]),
        .res_bit   (cmp_binary),
        .word_send (w_drain_end),
        .word_last (w_chan_end),
        .word_ch   (r_ch),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_last  (out_last),
        .xfer      (w_xfer)
    );

`ifdef CMP_SCHED_PERF_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_start_ok) begin
            r_stall_cnt <= '0;
        end else if (out_valid && !out_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_compare_block3_sched.sv
// ============================================================================
// Module      : tb_compare_block3_sched
// Description : Self-checking bench for compare_block3_sched with memory and
//               compare-stage models; second instance covers CH_NUM=1.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_compare_block3_sched;

    localparam int CH_NUM    = 2;
    localparam int WIN_NUM   = 10;
    localparam int PACK_W    = 8;
    localparam int WIN_AW    = 10;
    localparam int B_WIN_NUM = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut_a signals
    logic        start, busy, done, thr_rd_en, thr_load, win_rd_en, cmp_binary;
    logic        out_valid, out_ready, out_last;
    logic [0:0]  thr_rd_addr, out_ch;
    logic [23:0] thr_rd_data, thr_out;
    logic [9:0]  win_rd_addr;
    logic [55:0] win_rd_data, cmp_data;
    logic [7:0]  out_data;
    // dut_b signals
    logic        start_b, busy_b, done_b, thr_rd_en_b, thr_load_b, win_rd_en_b, cmp_binary_b;
    logic        out_valid_b, out_ready_b, out_last_b;
    logic [0:0]  thr_rd_addr_b, out_ch_b;
    logic [23:0] thr_rd_data_b, thr_out_b;
    logic [9:0]  win_rd_addr_b;
    logic [55:0] win_rd_data_b, cmp_data_b;
    logic [7:0]  out_data_b;
`ifdef CMP_SCHED_PERF_EN
    logic [15:0] perf_a, perf_b;
`endif

    compare_block3_sched #(.CH_NUM(CH_NUM), .WIN_NUM(WIN_NUM), .PACK_W(PACK_W), .WIN_AW(WIN_AW)) dut_a (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .thr_rd_en(thr_rd_en), .thr_rd_addr(thr_rd_addr), .thr_rd_data(thr_rd_data),
        .thr_out(thr_out), .thr_load(thr_load),
        .win_rd_en(win_rd_en), .win_rd_addr(win_rd_addr), .win_rd_data(win_rd_data),
        .cmp_data(cmp_data), .cmp_binary(cmp_binary),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_ch(out_ch), .out_last(out_last)
`ifdef CMP_SCHED_PERF_EN
        , .perf_stall_cnt(perf_a)
`endif
    );

    compare_block3_sched #(.CH_NUM(1), .WIN_NUM(B_WIN_NUM), .PACK_W(PACK_W), .WIN_AW(WIN_AW)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
        .thr_rd_en(thr_rd_en_b), .thr_rd_addr(thr_rd_addr_b), .thr_rd_data(thr_rd_data_b),
        .thr_out(thr_out_b), .thr_load(thr_load_b),
        .win_rd_en(win_rd_en_b), .win_rd_addr(win_rd_addr_b), .win_rd_data(win_rd_data_b),
        .cmp_data(cmp_data_b), .cmp_binary(cmp_binary_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
        .out_ch(out_ch_b), .out_last(out_last_b)
`ifdef CMP_SCHED_PERF_EN
        , .perf_stall_cnt(perf_b)
`endif
    );

    logic [23:0] thr_mem [2];
    logic [55:0] win_mem [1024];

    // Compare-stage stand-in: 7-lane signed int8 max against signed thr[11:0].
    function automatic logic golden_bit(input logic [23:0] thr, input logic [55:0] win);
        int mx;
        mx = -128;
        for (int l = 0; l < 7; l++) begin
            if (int'($signed(win[l*8 +: 8])) > mx) mx = int'($signed(win[l*8 +: 8]));
        end
        return mx >= int'($signed(thr[11:0]));
    endfunction

    logic [23:0] cs_thr, cs_thr_b;
    logic        cs_s1, cs_s2, cs_s1_b, cs_s2_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            thr_rd_data <= '0; win_rd_data <= '0; cs_thr <= '0; cs_s1 <= 1'b0; cs_s2 <= 1'b0;
            thr_rd_data_b <= '0; win_rd_data_b <= '0; cs_thr_b <= '0; cs_s1_b <= 1'b0; cs_s2_b <= 1'b0;
        end else begin
            if (thr_rd_en)   thr_rd_data   <= thr_mem[thr_rd_addr];
            if (win_rd_en)   win_rd_data   <= win_mem[win_rd_addr];
            if (thr_load)    cs_thr        <= thr_out;
            cs_s1 <= golden_bit(cs_thr, cmp_data);
            cs_s2 <= cs_s1;
            if (thr_rd_en_b) thr_rd_data_b <= thr_mem[thr_rd_addr_b];
            if (win_rd_en_b) win_rd_data_b <= win_mem[win_rd_addr_b];
            if (thr_load_b)  cs_thr_b      <= thr_out_b;
            cs_s1_b <= golden_bit(cs_thr_b, cmp_data_b);
            cs_s2_b <= cs_s1_b;
        end
    end
    assign cmp_binary   = cs_s2;
    assign cmp_binary_b = cs_s2_b;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    typedef struct packed {
        logic [7:0] data;
        logic       ch;
        logic       last;
    } word_t;

    word_t exp_q[$];

    task automatic push_model();
        logic [7:0] w;
        for (int ch = 0; ch < CH_NUM; ch++) begin
            for (int g = 0; g < WIN_NUM; g += PACK_W) begin
                w = '0;
                for (int i = 0; i < PACK_W && g + i < WIN_NUM; i++)
                    w[i] = golden_bit(thr_mem[ch], win_mem[ch*WIN_NUM + g + i]);
                exp_q.push_back('{data: w, ch: 1'(ch), last: (g + PACK_W >= WIN_NUM)});
            end
        end
    endtask

    task automatic randomize_mem();
        logic [63:0] r;
        for (int ch = 0; ch < CH_NUM; ch++)
            thr_mem[ch] = {12'h0, 12'($urandom_range(0, 255)) - 12'd128};
        for (int a = 0; a < CH_NUM*WIN_NUM; a++) begin
            r = {$urandom, $urandom};
            win_mem[a] = r[55:0];
        end
    endtask

    // Monitor state
    int cyc = 0;
    int done_cnt = 0, done_cyc = 0, acc_cyc = 0, load_cnt = 0;
    int hold_err = 0, thr_err = 0, stall_seen = 0;
    logic       p_stall = 1'b0;
    logic [9:0] p_word  = '0;
    logic [23:0] p_thr  = '0;
    logic [2:0]  ifl    = '0;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        word_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                ifl = '0; p_thr = thr_out; p_stall = 1'b0;
            end else begin
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("extra_word", 64'(exp_q.size()), 64'd1);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("word", {out_data, out_ch, out_last}, e);
                    end
                    if (out_last && out_ch == 1'b1) acc_cyc = cyc;
                end
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (thr_load) begin
                    load_cnt++;
                    if (thr_out !== thr_mem[thr_rd_addr]) thr_err++;
                end
                if (p_stall && (!out_valid || {out_data, out_ch, out_last} !== p_word)) hold_err++;
                if (out_valid && win_rd_en) hold_err++;
                if (out_valid && !out_ready) stall_seen++;
                if (thr_out !== p_thr && (ifl != 3'b0 || win_rd_en)) thr_err++;
                p_stall = out_valid && !out_ready;
                p_word  = {out_data, out_ch, out_last};
                p_thr   = thr_out;
                ifl     = {ifl[1:0], win_rd_en};
            end
        end
    end

    // Ready driver: 0 = always ready, 1 = random, 2 = stall first 20 valid cycles
    int rmode = 0;
    int stall_left = 0;
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rmode)
                1: out_ready = 1'($urandom_range(0, 1));
                2: begin
                    if (out_valid && stall_left > 0) begin
                        out_ready = 1'b0; stall_left--;
                    end else out_ready = 1'b1;
                end
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic run_a(input int mode, input bit dbl);
        int d0, l0, h0, t0, s0;
        d0 = done_cnt; l0 = load_cnt; h0 = hold_err; t0 = thr_err; s0 = stall_seen;
        rmode = mode; stall_left = 20;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        check_eq("busy_after_start", busy, 1);
        if (dbl) begin
            repeat (15) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        for (int i = 0; i < 3000 && done_cnt == d0; i++) @(posedge clk);
        repeat (20) @(posedge clk);
        #1;
        check_eq("done_count", 64'(done_cnt - d0), 1);
        check_eq("done_delay", 64'(done_cyc - acc_cyc), 1);
        check_eq("words_left", 64'(exp_q.size()), 0);
        check_eq("thr_load_count", 64'(load_cnt - l0), CH_NUM);
        check_eq("hold_errors", 64'(hold_err - h0), 0);
        check_eq("thr_errors", 64'(thr_err - t0), 0);
        check_eq("busy_idle", busy, 0);
        if (mode == 2) begin
            check_eq("stall_cycles", 64'(stall_seen - s0), 20);
`ifdef CMP_SCHED_PERF_EN
            check_eq("perf_stall_cnt", perf_a, 20);
`endif
        end
        exp_q.delete();
        rmode = 0;
    endtask

    typedef struct packed {
        logic [23:0] thr0;
        logic [23:0] thr1;
        logic [7:0]  fill;
        logic [31:0] words;   // {ch1 g1, ch1 g0, ch0 g1, ch0 g0}
    } vec_t;

    vec_t vecs [5];
    logic [31:0] wv;
    logic [7:0]  bexp;
    bit          ok;
    int          d0;

    initial begin
        vecs[0] = '{thr0: 24'h7FF7FF, thr1: 24'h000000, fill: 8'h05, words: 32'h03FF_0000};
        vecs[1] = '{thr0: 24'h000004, thr1: 24'h000006, fill: 8'h05, words: 32'h0000_03FF};
        vecs[2] = '{thr0: 24'h000FFB, thr1: 24'h7FF7FF, fill: 8'hFB, words: 32'h0000_03FF};
        vecs[3] = '{thr0: 24'h000FFF, thr1: 24'h000000, fill: 8'h80, words: 32'h0000_0000};
        vecs[4] = '{thr0: 24'h000000, thr1: 24'h000000, fill: 8'h00, words: 32'h03FF_03FF};

        start = 1'b0; start_b = 1'b0; out_ready_b = 1'b1;
        randomize_mem();
        repeat (3) @(posedge clk);
        check_eq("reset_outputs_a", |{busy, done, thr_rd_en, thr_rd_addr, thr_out, thr_load, win_rd_en,
                 win_rd_addr, cmp_data, out_valid, out_data, out_ch, out_last}, 0);
        check_eq("reset_outputs_b", |{busy_b, done_b, thr_rd_en_b, thr_load_b, win_rd_en_b,
                 out_valid_b, out_data_b, out_last_b}, 0);
        #1 rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            thr_mem[0] = vecs[v].thr0;
            thr_mem[1] = vecs[v].thr1;
            for (int a = 0; a < CH_NUM*WIN_NUM; a++) win_mem[a] = {7{vecs[v].fill}};
            wv = vecs[v].words;
            for (int k = 0; k < 4; k++)
                exp_q.push_back('{data: wv[k*8 +: 8], ch: 1'(k / 2), last: 1'(k % 2)});
            run_a(0, 1'b0);
        end

        for (int r = 0; r < 3; r++) begin
            randomize_mem();
            push_model();
            run_a(1, r == 1);
        end

        randomize_mem();
        push_model();
        run_a(2, 1'b0);

        // Reset while channel 1 is issuing, then a clean rerun
        randomize_mem();
        push_model();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            if (win_rd_en && win_rd_addr >= 10'(WIN_NUM)) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_eq("reach_ch1_issue", ok, 1);
        rst = 1'b1;
        #1;
        check_eq("rst_mid_outputs", |{busy, done, thr_rd_en, thr_rd_addr, thr_out, thr_load, win_rd_en,
                 win_rd_addr, cmp_data, out_valid, out_data, out_ch, out_last}, 0);
        exp_q.delete();
        d0 = done_cnt;
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        check_eq("no_done_after_rst", 64'(done_cnt - d0), 0);
        check_eq("idle_after_rst", busy, 0);
        push_model();
        run_a(0, 1'b0);

        // Single channel, fewer windows than a word
        randomize_mem();
        bexp = '0;
        for (int i = 0; i < B_WIN_NUM; i++) bexp[i] = golden_bit(thr_mem[0], win_mem[i]);
        @(posedge clk); #1 start_b = 1'b1;
        @(posedge clk); #1 start_b = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid_b) begin ok = 1'b1; break; end
            @(posedge clk); #1;
        end
        check_eq("b_word_seen", ok, 1);
        check_eq("b_word", {out_data_b, out_ch_b, out_last_b}, {bexp, 1'b0, 1'b1});
        @(posedge clk); #1;
        check_eq("b_done", done_b, 1);
        @(posedge clk); #1;
        check_eq("b_done_once", {done_b, busy_b}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
